vx_lane_serializer: RTL and testbench
=====================================

Name: vx_lane_serializer

Overview:
- Converts one N-lane SIMD beat (active-lane mask plus per-lane data) into a stream of single-lane beats, one active lane per cycle.
- Lanes are emitted in priority order.
- Sits directly downstream of the OR prefix scan:
  - The OR-scan of the remaining mask, ANDed with its own complement shifted by one, yields the one-hot next lane.
  - The serializer registers, sequences and hands off the result.
- Used for per-thread memory/CSR requests and for divergent-lane writeback.

Parameters:
- NUM_LANES, 4, lane count N (>=1).
- DATA_WIDTH, 32, bits per lane.
- REVERSE, 0.
  - 0: lowest lane first.
  - 1: highest lane first (same convention as the scan direction).
- LANE_BITS, max(1,$clog2(NUM_LANES)), derived; do not override.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- valid_in  in  1  input beat valid.
- mask_in  in  NUM_LANES  active-lane mask.
- data_in  in  NUM_LANES*DATA_WIDTH  lane data; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- ready_in  out  1  input accepted when valid_in&ready_in.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WIDTH  selected lane data.
- lane_out  out  LANE_BITS  selected lane index.
- last_out  out  1  final active lane of the current input beat.
- ready_out  in  1  downstream ready.

Behaviour:
- State IDLE/BUSY. Registers: rem_mask[N], data_r[N*W].
- Reset (async assert, sync deassert handled externally):
  - State=IDLE, rem_mask=0.
  - valid_out=0, last_out=0, lane_out=0, data_out=0.
  - ready_in=0 while reset_n low; ready_in=1 in IDLE after release.
- Next-lane select is combinational from rem_mask:
  - scan = inclusive OR-scan in REVERSE direction.
  - onehot = scan & ~(scan shifted by one toward the scan direction).
  - lane_out = encode(onehot); data_out = data_r lane lane_out.
- last_out = (rem_mask has exactly one bit set), i.e. rem_mask & ~onehot == 0.
- ready_in = IDLE | (BUSY & last_out & ready_out). Accepting in the same cycle as the last handshake gives zero bubble between beats.
- IDLE:
  - Accept with mask!=0: load rem_mask/data_r -> BUSY.
  - Accept with mask==0: beat is consumed and dropped, stay IDLE, no output.
- BUSY:
  - valid_out=1.
  - Handshake (valid_out&ready_out) clears the onehot bit from rem_mask.
  - On the last handshake: if a new nonzero beat is accepted, load it and stay BUSY; otherwise go to IDLE.
- Latency: first output beat 1 cycle after accept.
- Throughput: popcount(mask) cycles per input beat under no backpressure.
- Backpressure: with valid_out&~ready_out, data_out/lane_out/last_out are held stable and rem_mask is unchanged.
- NUM_LANES==1: LANE_BITS=1, lane_out always 0, last_out always 1 in BUSY.
- Reset mid-operation: pending lanes are discarded immediately; no partial beat is emitted after release.

Optional Feature:
- Macro: VX_LANE_SERIALIZER_PERF_EN.
- Defined:
  - Adds output perf_stalls_out [31:0].
  - Counter increments each cycle valid_out&~ready_out and saturates at 2^32-1.
  - Cleared by reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vx_lane_ser_pkg:
  - state enum (IDLE=1'b0, BUSY=1'b1).
  - function lane_bits(n).
  - function popcount-free onehot2idx.
- One natural sub-module, vx_lane_find_first (combinational):
  - Instantiates the OR prefix scan and the onehot mask/encode.
  - Outputs onehot, index, is_last.
- The top holds the state machine and registers.

Test Plan:
- Basic, N=4, W=32, REVERSE=0:
  - Stimulus: mask=4'b1011, data={D3=0x33,D2=0x22,D1=0x11,D0=0x00}, ready_out=1.
  - Response: cycles 1-3 emit (lane0,0x00,last0), (lane1,0x11,last0), (lane3,0x33,last1); ready_in high in cycle 3.
- Backpressure:
  - Stimulus: same beat, ready_out low for 2 cycles at the second output.
  - Response: (lane1,0x11) held 3 cycles; total 5 output cycles; no lane lost or duplicated.
- Back-to-back:
  - Stimulus: beat A mask 4'b0100 then beat B mask 4'b1001, both presented continuously.
  - Response: lane2(A,last) -> lane0(B) -> lane3(B,last) in consecutive cycles, no bubble.
- Zero mask and REVERSE=1:
  - Stimulus: mask=0 accepted.
  - Response: no valid_out, ready_in stays 1.
  - Stimulus: REVERSE=1, mask=4'b0110.
  - Response: lane2 then lane1(last).
- Reset mid-operation:
  - Stimulus: assert reset_n=0 after the first of three lanes.
  - Response: valid_out drops asynchronously; after release IDLE, ready_in=1, no residual output.
- Perf counter (with VX_LANE_SERIALIZER_PERF_EN):
  - Stimulus: 4 stall cycles.
  - Response: perf_stalls_out=4; 0 after reset.

Source files
------------

// File: rtl/vx_lane_serializer_pkg.sv
// ---------------------------------------------------------------------------
// vx_lane_ser_pkg
// Shared types and helpers for the lane serializer:
//   ser_state_e  - serializer state (IDLE / BUSY)
//   lane_bits()  - width of a lane index for n lanes (never below 1)
//   onehot2idx() - encodes a one-hot lane vector into its index without a
//                  priority chain (ORs the indices of all set bits)
// ---------------------------------------------------------------------------
package vx_lane_ser_pkg;

  // Widest lane vector the one-hot encoder accepts.
  localparam int MAX_LANES = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ser_state_e;

  function automatic int lane_bits(input int n);
    int result;
    if (n <= 1) begin
      result = 1;
    end else begin
      result = $clog2(n);
    end
    return result;
  endfunction

  // Valid only for a one-hot (or all-zero) input; zero maps to index 0.
  function automatic logic [31:0] onehot2idx(input logic [MAX_LANES-1:0] onehot);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (onehot[i]) begin
        idx = idx | 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_lane_serializer_find_first.sv
// ---------------------------------------------------------------------------
// vx_lane_find_first
// Combinational next-lane finder. An inclusive OR prefix scan of the mask in
// the priority direction is ANDed with its own complement shifted by one lane,
// leaving only the first set lane.
// Ports:
//   mask     in   NUM_LANES  remaining active lanes
//   onehot   out  NUM_LANES  first active lane, one-hot (zero if mask is zero)
//   index    out  LANE_BITS  encoded index of onehot
//   is_last  out  1          mask holds exactly one active lane
// ---------------------------------------------------------------------------
module vx_lane_find_first
  import vx_lane_ser_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter bit REVERSE   = 1'b0,
  parameter int LANE_BITS = lane_bits(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  output logic [NUM_LANES-1:0] onehot,
  output logic [LANE_BITS-1:0] index,
  output logic                 is_last
);

  logic [NUM_LANES-1:0] scan_s;
  logic [NUM_LANES-1:0] scan_prev_s;

  // Inclusive OR scan toward the low-priority end; scan_prev_s is the scan
  // shifted one lane so that only the first set lane survives the AND-NOT.
  always_comb begin
    scan_s      = '0;
    scan_prev_s = '0;
    if (REVERSE) begin
      scan_s[NUM_LANES-1] = mask[NUM_LANES-1];
      for (int i = NUM_LANES - 2; i >= 0; i--) begin
        scan_s[i] = scan_s[i+1] | mask[i];
      end
      scan_prev_s = scan_s >> 1;
    end else begin
      scan_s[0] = mask[0];
      for (int i = 1; i < NUM_LANES; i++) begin
        scan_s[i] = scan_s[i-1] | mask[i];
      end
      scan_prev_s = scan_s << 1;
    end
  end

  assign onehot  = scan_s & ~scan_prev_s;
  assign index   = LANE_BITS'(onehot2idx(MAX_LANES'(onehot)));
  // An empty mask is not "last": nothing is being emitted.
  assign is_last = (|onehot) & ~(|(mask & ~onehot));

endmodule

// File: rtl/vx_lane_serializer.sv
// ---------------------------------------------------------------------------
// vx_lane_serializer
// Converts one N-lane SIMD beat (mask + per-lane data) into a stream of
// single-lane beats, one active lane per cycle, in priority order
// (REVERSE=0: lowest lane first, REVERSE=1: highest lane first).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   valid_in          input beat valid
//   mask_in           active-lane mask
//   data_in           lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready_in          input accepted when valid_in & ready_in
//   valid_out         output beat valid
//   data_out          selected lane data
//   lane_out          selected lane index
//   last_out          final active lane of the current input beat
//   ready_out         downstream ready
//   perf_stalls_out   (only with VX_LANE_SERIALIZER_PERF_EN) saturating
//                     count of cycles with valid_out & ~ready_out
// Optional feature macro: VX_LANE_SERIALIZER_PERF_EN
// ---------------------------------------------------------------------------
module vx_lane_serializer
  import vx_lane_ser_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit REVERSE    = 1'b0,
  parameter int LANE_BITS  = lane_bits(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            valid_in,
  input  logic [NUM_LANES-1:0]            mask_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  output logic                            ready_in,
  output logic                            valid_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [LANE_BITS-1:0]            lane_out,
  output logic                            last_out,
  input  logic                            ready_out
`ifdef VX_LANE_SERIALIZER_PERF_EN
  ,
  output logic [31:0]                     perf_stalls_out
`endif
);

  ser_state_e                      state_r;
  logic [NUM_LANES-1:0]            rem_mask_r;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_r;

  logic [NUM_LANES-1:0]  onehot_s;
  logic [LANE_BITS-1:0]  index_s;
  logic                  is_last_s;
  logic                  busy_s;
  logic                  accept_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] data_sel_s;

  vx_lane_find_first #(
    .NUM_LANES (NUM_LANES),
    .REVERSE   (REVERSE),
    .LANE_BITS (LANE_BITS)
  ) u_find_first (
    .mask    (rem_mask_r),
    .onehot  (onehot_s),
    .index   (index_s),
    .is_last (is_last_s)
  );

  assign busy_s   = (state_r == BUSY);
  // Accepting on the last handshake lets the next beat follow with no bubble.
  assign ready_in = reset_n & (~busy_s | (is_last_s & ready_out));
  assign accept_s = valid_in & ready_in;
  // A zero-mask beat is consumed but never loaded.
  assign load_s   = accept_s & (|mask_in);

  // Serializer state machine: load a beat, then retire one lane per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      rem_mask_r <= '0;
      data_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r    <= BUSY;
            rem_mask_r <= mask_in;
            data_r     <= data_in;
          end else begin
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          if (ready_out) begin
            if (is_last_s) begin
              if (load_s) begin
                state_r    <= BUSY;
                rem_mask_r <= mask_in;
                data_r     <= data_in;
              end else begin
                state_r    <= IDLE;
                rem_mask_r <= '0;
              end
            end else begin
              rem_mask_r <= rem_mask_r & ~onehot_s;
            end
          end else begin
            rem_mask_r <= rem_mask_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          rem_mask_r <= '0;
        end
      endcase
    end
  end

  // One-hot data mux; an empty remaining mask yields zero data.
  always_comb begin
    data_sel_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot_s[i]) begin
        data_sel_s = data_r[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  assign valid_out = busy_s;
  assign data_out  = data_sel_s;
  assign lane_out  = index_s;
  assign last_out  = is_last_s;

`ifdef VX_LANE_SERIALIZER_PERF_EN
  logic [31:0] perf_stalls_r;

  // Saturating count of cycles in which a valid output is held by backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stalls_r <= 32'd0;
    end else if (busy_s && !ready_out && (perf_stalls_r != 32'hFFFF_FFFF)) begin
      perf_stalls_r <= perf_stalls_r + 32'd1;
    end else begin
      perf_stalls_r <= perf_stalls_r;
    end
  end

  assign perf_stalls_out = perf_stalls_r;
`endif

endmodule

// File: tb/tb_vx_lane_serializer.sv
// ---------------------------------------------------------------------------
// tb_vx_lane_serializer
// Self-checking bench: directed scenarios plus a randomized run compared
// against a queue-based reference model of the expected lane stream.
// dut0 uses REVERSE=0, dut1 uses REVERSE=1.
// ---------------------------------------------------------------------------
module tb_vx_lane_serializer;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LB = 2;

  typedef struct {
    logic [LB-1:0] lane;
    logic [W-1:0]  data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  logic           valid_in, ready_out, ready_in, valid_out, last_out;
  logic [N-1:0]   mask_in;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   data_out;
  logic [LB-1:0]  lane_out;

  logic           rv_valid_in, rv_ready_out, rv_ready_in, rv_valid_out, rv_last_out;
  logic [N-1:0]   rv_mask_in;
  logic [N*W-1:0] rv_data_in;
  logic [W-1:0]   rv_data_out;
  logic [LB-1:0]  rv_lane_out;

`ifdef VX_LANE_SERIALIZER_PERF_EN
  logic [31:0] perf0;
  logic [31:0] perf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_lane_serializer #(.NUM_LANES(N), .DATA_WIDTH(W), .REVERSE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mask_in(mask_in),
    .data_in(data_in), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .lane_out(lane_out), .last_out(last_out),
    .ready_out(ready_out)
`ifdef VX_LANE_SERIALIZER_PERF_EN
    , .perf_stalls_out(perf0)
`endif
  );

  vx_lane_serializer #(.NUM_LANES(N), .DATA_WIDTH(W), .REVERSE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .valid_in(rv_valid_in), .mask_in(rv_mask_in),
    .data_in(rv_data_in), .ready_in(rv_ready_in), .valid_out(rv_valid_out),
    .data_out(rv_data_out), .lane_out(rv_lane_out), .last_out(rv_last_out),
    .ready_out(rv_ready_out)
`ifdef VX_LANE_SERIALIZER_PERF_EN
    , .perf_stalls_out(perf1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid_in = 1'b0; mask_in = '0; data_in = '0; ready_out = 1'b1;
    rv_valid_in = 1'b0; rv_mask_in = '0; rv_data_in = '0; rv_ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs ready_in=%b valid_out=%b expected 0 0", ready_in, valid_out);
    end
    checks++;
    if (lane_out !== 2'd0 || last_out !== 1'b0 || data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_out lane=%0d last=%b data=%h expected 0 0 0", lane_out, last_out, data_out);
    end
`ifdef VX_LANE_SERIALIZER_PERF_EN
    checks++;
    if (perf0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf perf=%0d expected 0", perf0);
    end
`endif
    reset_n = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready_in=%b valid_out=%b expected 1 0", ready_in, valid_out);
    end
    step();
  endtask

  task automatic test_basic();
    logic [LB-1:0] exp_lane [3];
    logic [W-1:0]  exp_data [3];
    exp_lane = '{2'd0, 2'd1, 2'd3};
    exp_data = '{32'h00, 32'h11, 32'h33};
    valid_in = 1'b1; mask_in = 4'b1011; ready_out = 1'b1;
    data_in = {32'h33, 32'h22, 32'h11, 32'h00};
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept ready_in=%b expected 1", ready_in);
    end
    step();
    valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || lane_out !== exp_lane[c] || data_out !== exp_data[c] || last_out !== (c == 2)) begin
        errors++;
        $display("FAIL basic_beat%0d valid=%b lane=%0d data=%h last=%b expected 1 %0d %h %b",
                 c, valid_out, lane_out, data_out, last_out, exp_lane[c], exp_data[c], (c == 2));
      end
      checks++;
      if (ready_in !== (c == 2)) begin
        errors++;
        $display("FAIL basic_ready%0d ready_in=%b expected %b", c, ready_in, (c == 2));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle valid_out=%b expected 0", valid_out);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic          rdy      [5];
    logic [LB-1:0] exp_lane [5];
    logic [W-1:0]  exp_data [5];
    rdy      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_lane = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    exp_data = '{32'h00, 32'h11, 32'h11, 32'h11, 32'h33};
    valid_in = 1'b1; mask_in = 4'b1011; ready_out = 1'b1;
    data_in = {32'h33, 32'h22, 32'h11, 32'h00};
    step();
    valid_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ready_out = rdy[c];
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || lane_out !== exp_lane[c] || data_out !== exp_data[c] || last_out !== (c == 4)) begin
        errors++;
        $display("FAIL bp_beat%0d valid=%b lane=%0d data=%h last=%b expected 1 %0d %h %b",
                 c, valid_out, lane_out, data_out, last_out, exp_lane[c], exp_data[c], (c == 4));
      end
      step();
    end
    ready_out = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_count valid_out=%b after 5 beats expected 0", valid_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    ready_out = 1'b1;
    valid_in = 1'b1; mask_in = 4'b0100;
    data_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step();
    mask_in = 4'b1001;
    data_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || lane_out !== 2'd2 || data_out !== 32'hA2 || last_out !== 1'b1 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a valid=%b lane=%0d data=%h last=%b ready_in=%b expected 1 2 a2 1 1",
               valid_out, lane_out, data_out, last_out, ready_in);
    end
    step();
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || lane_out !== 2'd0 || data_out !== 32'hB0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_b0 valid=%b lane=%0d data=%h last=%b expected 1 0 b0 0",
               valid_out, lane_out, data_out, last_out);
    end
    step();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || lane_out !== 2'd3 || data_out !== 32'hB3 || last_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b3 valid=%b lane=%0d data=%h last=%b expected 1 3 b3 1",
               valid_out, lane_out, data_out, last_out);
    end
    step();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle valid_out=%b expected 0", valid_out);
    end
    step();
  endtask

  task automatic test_zero_mask();
    ready_out = 1'b1;
    valid_in = 1'b1; mask_in = 4'b0000; data_in = {4{$urandom()}};
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept ready_in=%b expected 1", ready_in);
    end
    step();
    valid_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
        errors++;
        $display("FAIL zero_idle%0d valid_out=%b ready_in=%b expected 0 1", c, valid_out, ready_in);
      end
      step();
    end
  endtask

  task automatic test_reverse();
    rv_ready_out = 1'b1;
    rv_valid_in = 1'b1; rv_mask_in = 4'b0110;
    rv_data_in = {32'h33, 32'h22, 32'h11, 32'h00};
    step();
    rv_valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (rv_valid_out !== 1'b1 || rv_lane_out !== 2'd2 || rv_data_out !== 32'h22 || rv_last_out !== 1'b0) begin
      errors++;
      $display("FAIL rev_first valid=%b lane=%0d data=%h last=%b expected 1 2 22 0",
               rv_valid_out, rv_lane_out, rv_data_out, rv_last_out);
    end
    step();
    @(negedge clk);
    checks++;
    if (rv_valid_out !== 1'b1 || rv_lane_out !== 2'd1 || rv_data_out !== 32'h11 || rv_last_out !== 1'b1) begin
      errors++;
      $display("FAIL rev_second valid=%b lane=%0d data=%h last=%b expected 1 1 11 1",
               rv_valid_out, rv_lane_out, rv_data_out, rv_last_out);
    end
    step();
    @(negedge clk);
    checks++;
    if (rv_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rev_idle valid_out=%b expected 0", rv_valid_out);
    end
    step();
  endtask

  task automatic test_perf();
`ifdef VX_LANE_SERIALIZER_PERF_EN
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    valid_in = 1'b1; mask_in = 4'b0001; data_in = {4{32'h5A5A_0001}}; ready_out = 1'b0;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    ready_out = 1'b1;
    @(negedge clk);
    checks++;
    if (perf0 !== 32'd4 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL perf_count perf=%0d valid_out=%b expected 4 1", perf0, valid_out);
    end
    step();
    step();
    checks++;
    if (perf0 !== 32'd4) begin
      errors++;
      $display("FAIL perf_hold perf=%0d expected 4", perf0);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (perf0 !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset perf=%0d expected 0", perf0);
    end
    reset_n = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    ready_out = 1'b1;
    valid_in = 1'b1; mask_in = 4'b0111;
    data_in = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
    step();
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || lane_out !== 2'd0 || data_out !== 32'h0A) begin
      errors++;
      $display("FAIL rmid_first valid=%b lane=%0d data=%h expected 1 0 0a", valid_out, lane_out, data_out);
    end
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b0 || last_out !== 1'b0 || lane_out !== 2'd0 || data_out !== 32'd0) begin
      errors++;
      $display("FAIL rmid_async valid=%b ready_in=%b last=%b lane=%0d data=%h expected 0 0 0 0 0",
               valid_out, ready_in, last_out, lane_out, data_out);
    end
    step();
    step();
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
        errors++;
        $display("FAIL rmid_after%0d valid_out=%b ready_in=%b expected 0 1", c, valid_out, ready_in);
      end
      step();
    end
  endtask

  // Randomized traffic against a queue of expected single-lane beats.
  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic exp_ready;
    int   total;
    int   k;
    for (int cyc = 0; cyc < 412; cyc++) begin
      if (cyc < 400) begin
        valid_in  = ($urandom_range(0, 3) != 0);
        mask_in   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom());
        data_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
        ready_out = ($urandom_range(0, 3) != 0);
      end else begin
        valid_in  = 1'b0;
        ready_out = 1'b1;
      end
      @(negedge clk);
      exp_ready = (q.size() == 0) || (q.size() == 1 && ready_out);
      checks++;
      if (valid_out !== (q.size() != 0) || ready_in !== exp_ready) begin
        errors++;
        $display("FAIL rand_hs cyc=%0d valid_out=%b ready_in=%b expected %b %b",
                 cyc, valid_out, ready_in, (q.size() != 0), exp_ready);
      end
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (lane_out !== e.lane || data_out !== e.data || last_out !== e.last) begin
          errors++;
          $display("FAIL rand_beat cyc=%0d lane=%0d data=%h last=%b expected %0d %h %b",
                   cyc, lane_out, data_out, last_out, e.lane, e.data, e.last);
        end
        if (ready_out) begin
          void'(q.pop_front());
        end
      end
      if (valid_in && exp_ready) begin
        total = $countones(mask_in);
        k = 0;
        for (int l = 0; l < N; l++) begin
          if (mask_in[l]) begin
            k++;
            e.lane = LB'(l);
            e.data = data_in[l*W +: W];
            e.last = (k == total);
            q.push_back(e);
          end
        end
      end
      step();
    end
    checks++;
    if (q.size() != 0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain pending=%0d valid_out=%b expected 0 0", q.size(), valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_mask();
    test_reverse();
    test_perf();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
